// File: rtl/syscall_ctrl_pkg.sv
// Shared service codes, FSM state encodings and address helpers for the SYSCALL controller.
package syscall_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    function automatic logic [31:0] word_addr(input logic [31:0] p);
        return {p[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/syscall_ctrl_byte_sel.sv
// Little-endian byte lane select from the fetched memory word.
module syscall_byte_sel (
    input  logic [31:0] word,
    input  logic [1:0]  sel,
    output logic [7:0]  sel_byte
);

    always_comb begin
        sel_byte = '0;
        case (sel)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = '0;
        endcase
    end

endmodule

// File: rtl/syscall_ctrl.sv
// SYSCALL service controller: print-string, print-char and exit, stalling the core
// while a service runs and streaming characters to the console handshake.
module syscall_ctrl
    import syscall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall,
    input  logic [31:0] vreg,
    input  logic [31:0] areg,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        done,
    output logic        unsup,
    output logic        trunc,
    output logic        halt
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    logic [2:0]    state;
    logic [31:0]   vreg_q;
    logic [31:0]   areg_q;
    logic [31:0]   ptr;
    logic [31:0]   wbuf;
    logic [CW-1:0] cnt;
    logic [7:0]    chr_q;
    logic          single;
    logic          unsup_q;
    logic          trunc_q;
    logic [7:0]    sel_byte;
    logic          str_nul;

    syscall_byte_sel u_byte_sel (
        .word     (wbuf),
        .sel      (ptr[1:0]),
        .sel_byte (sel_byte)
    );

    // A NUL terminates only the string service; print-char emits its byte as-is.
    assign str_nul = !single && (sel_byte == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vreg_q  <= '0;
            areg_q  <= '0;
            ptr     <= '0;
            wbuf    <= '0;
            cnt     <= '0;
            chr_q   <= '0;
            single  <= 1'b0;
            unsup_q <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (syscall) begin
                        vreg_q  <= vreg;
                        areg_q  <= areg;
                        single  <= 1'b0;
                        unsup_q <= 1'b0;
                        trunc_q <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (vreg_q == SVC_PRINT_STR) begin
                        ptr   <= areg_q;
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end else if (vreg_q == SVC_PRINT_CHAR) begin
                        chr_q  <= areg_q[7:0];
                        single <= 1'b1;
                        state  <= ST_EMIT;
                    end else if (vreg_q == SVC_EXIT) begin
                        state <= ST_HALT;
                    end else begin
                        unsup_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_ack) begin
                        wbuf  <= mem_rdata;
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (single) begin
                        if (char_ready) state <= ST_DONE;
                    end else if (str_nul) begin
                        state <= ST_DONE;
                    end else if (char_ready) begin
                        ptr <= ptr + 32'd1;
                        cnt <= cnt + 1'b1;
                        // Length limit wins over the word-boundary refetch.
                        if (cnt == CW'(MAX_LEN - 1)) begin
                            trunc_q <= 1'b1;
                            state   <= ST_DONE;
                        end else if (ptr[1:0] == 2'b11) begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall      = rst_n && ((state != ST_IDLE) || syscall);
    assign mem_req    = (state == ST_FETCH);
    assign mem_addr   = mem_req ? word_addr(ptr) : '0;
    assign char_valid = (state == ST_EMIT) && !str_nul;
    assign char_data  = char_valid ? (single ? chr_q : sel_byte) : '0;
    assign done       = (state == ST_DONE);
    assign unsup      = done && unsup_q;
    assign trunc      = done && trunc_q;
    assign halt       = (state == ST_HALT);

endmodule
